// File: rtl/sccb_init_seq.sv
// rtl/sccb_init_seq.sv - camera register-initialisation sequencer feeding the SCCB master
//
// Purpose:
//   On a rising edge of go, wait a power-up delay, then walk a 64-entry
//   {reg, data} table and issue one SCCB write per entry through the master's
//   one-cycle start strobe. Special entries: {FF,FF} ends the table and
//   {FF,N} waits N delay units without bus traffic. Each transaction is
//   guarded by a timeout. A NACK either aborts the sequence or, when
//   SCCB_INIT_RETRY_EN is defined, retries the same entry up to MAX_RETRY times.
//
// Optional feature macro: SCCB_INIT_RETRY_EN (undefined: any NACK -> ERROR).
//
// Ports:
//   sys_clock      in   system clock
//   reset          in   asynchronous, active-high reset
//   go             in   rising edge starts the sequence (ignored while busy)
//   sccb_start     out  one-cycle request to the SCCB master
//   sccb_dev_addr  out  [7:0] device write ID (constant DEV_ADDR)
//   sccb_reg_addr  out  [7:0] register sub-address of the current entry
//   sccb_wdata     out  [7:0] write data of the current entry
//   sccb_busy      in   master busy; start is withheld while high
//   sccb_done      in   one-cycle completion pulse from the master
//   sccb_nack      in   ACK error, meaningful only with sccb_done
//   init_busy      out  high from go until DONE or ERROR
//   init_done      out  sticky success flag
//   init_err       out  sticky failure flag
//   step_idx       out  [5:0] index of the current table entry
//
// Parameters TABLE_OVERRIDE / TABLE_IMAGE replace the built-in ROM with a
// packed 64x16 image (entry i at bits [16*i +: 16]) for board variants.

module sccb_init_seq #(
  parameter logic [7:0]    DEV_ADDR          = 8'h42,
  parameter int unsigned   DELAY_UNIT_CYCLES = 100000,
  parameter logic [7:0]    POWERUP_UNITS     = 8'd10,
  parameter int unsigned   GAP_CYCLES        = 16,
  parameter int unsigned   TIMEOUT_CYCLES    = 2000000,
  parameter int unsigned   MAX_RETRY         = 3,
  parameter bit            TABLE_OVERRIDE    = 1'b0,
  parameter logic [1023:0] TABLE_IMAGE       = '1
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       go,
  output logic       sccb_start,
  output logic [7:0] sccb_dev_addr,
  output logic [7:0] sccb_reg_addr,
  output logic [7:0] sccb_wdata,
  input  logic       sccb_busy,
  input  logic       sccb_done,
  input  logic       sccb_nack,
  output logic       init_busy,
  output logic       init_done,
  output logic       init_err,
  output logic [5:0] step_idx
);

`ifdef SCCB_INIT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE,
    POWERUP,
    FETCH,
    ISSUE,
    WAIT_DONE,
    DELAY,
    GAP,
    DONE,
    ERROR
  } state_t;

  // Power-up delay in clocks, saturated to 32 bits.
  localparam logic [39:0] PU_PROD      = 40'(POWERUP_UNITS) * 40'(DELAY_UNIT_CYCLES);
  localparam logic [31:0] POWERUP_LOAD = (PU_PROD[39:32] != 8'd0) ? 32'hFFFF_FFFF : PU_PROD[31:0];

  // The shared down-counter leaves its state when it reads 1, so a load of K
  // keeps the state for exactly K cycles (minimum one).
  localparam logic [31:0] GAP_LOAD     = (GAP_CYCLES == 0) ? 32'd1 : 32'(GAP_CYCLES);

  // The timeout counter is loaded on the start edge and already counts that
  // cycle, hence the minus one.
  localparam logic [31:0] TIMEOUT_LOAD = (TIMEOUT_CYCLES > 1) ? 32'(TIMEOUT_CYCLES - 1) : 32'd1;

  state_t      state;
  logic        go_q;
  logic [31:0] cnt;
  logic [7:0]  retry_cnt;
  logic        gap_retry;   // GAP returns to ISSUE for the same entry
  logic [15:0] entry;

  // Built-in table: OV7670 QVGA RGB565 bring-up.
  function automatic logic [15:0] rom_entry(input logic [5:0] idx);
    logic [15:0] e;
    case (idx)
      6'd0:    e = 16'h1280;  // COM7: soft reset
      6'd1:    e = 16'hFF0A;  // wait 10 units for the reset to settle
      6'd2:    e = 16'h1101;  // CLKRC: prescaler /2
      6'd3:    e = 16'h1214;  // COM7: QVGA, RGB
      6'd4:    e = 16'h40D0;  // COM15: RGB565, full range
      6'd5:    e = 16'h8C00;  // RGB444 off
      6'd6:    e = 16'h3A04;  // TSLB
      6'd7:    e = 16'h3DC0;  // COM13: gamma, UV sat
      6'd8:    e = 16'h1716;  // HSTART
      6'd9:    e = 16'h1804;  // HSTOP
      6'd10:   e = 16'h3280;  // HREF
      6'd11:   e = 16'h1902;  // VSTRT
      6'd12:   e = 16'h1A7A;  // VSTOP
      6'd13:   e = 16'h030A;  // VREF
      6'd14:   e = 16'h0C00;  // COM3
      6'd15:   e = 16'h3E00;  // COM14
      6'd16:   e = 16'h703A;  // scaling X
      6'd17:   e = 16'h7135;  // scaling Y
      6'd18:   e = 16'h7211;  // downsample
      6'd19:   e = 16'h73F0;  // PCLK divider
      6'd20:   e = 16'hA202;  // PCLK delay
      default: e = 16'hFFFF;  // end of table
    endcase
    return e;
  endfunction

  // Delay-entry length in clocks, saturated to 32 bits.
  function automatic logic [31:0] delay_clocks(input logic [7:0] units);
    logic [39:0] p;
    p = 40'(units) * 40'(DELAY_UNIT_CYCLES);
    return (p[39:32] != 8'd0) ? 32'hFFFF_FFFF : p[31:0];
  endfunction

  always_comb begin
    entry = rom_entry(step_idx);
    if (TABLE_OVERRIDE) begin
      entry = TABLE_IMAGE[{step_idx, 4'b0000} +: 16];
    end
  end

  assign sccb_dev_addr = DEV_ADDR;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      go_q          <= 1'b0;
      cnt           <= 32'd0;
      retry_cnt     <= 8'd0;
      gap_retry     <= 1'b0;
      sccb_start    <= 1'b0;
      sccb_reg_addr <= 8'd0;
      sccb_wdata    <= 8'd0;
      init_busy     <= 1'b0;
      init_done     <= 1'b0;
      init_err      <= 1'b0;
      step_idx      <= 6'd0;
    end else begin
      go_q       <= go;
      sccb_start <= 1'b0;

      case (state)
        IDLE: begin
          if (go && !go_q) begin
            init_done <= 1'b0;
            init_err  <= 1'b0;
            init_busy <= 1'b1;
            step_idx  <= 6'd0;
            cnt       <= POWERUP_LOAD;
            state     <= POWERUP;
          end
        end

        POWERUP: begin
          if (cnt <= 32'd1) begin
            state <= FETCH;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        FETCH: begin
          retry_cnt     <= 8'd0;
          sccb_reg_addr <= entry[15:8];
          sccb_wdata    <= entry[7:0];
          if (entry == 16'hFFFF) begin
            state <= DONE;
          end else if (entry[15:8] == 8'hFF) begin
            if (entry[7:0] == 8'd0) begin
              // zero-length delay skips straight to the inter-entry gap
              cnt       <= GAP_LOAD;
              gap_retry <= 1'b0;
              state     <= GAP;
            end else begin
              cnt   <= delay_clocks(entry[7:0]);
              state <= DELAY;
            end
          end else begin
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (!sccb_busy) begin
            sccb_start <= 1'b1;
            cnt        <= TIMEOUT_LOAD;
            state      <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          // done is checked first so it wins over a coincident timeout
          if (sccb_done) begin
            if (!sccb_nack) begin
              cnt       <= GAP_LOAD;
              gap_retry <= 1'b0;
              state     <= GAP;
            end else if (RETRY_EN && (32'(retry_cnt) < MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 8'd1;
              cnt       <= GAP_LOAD;
              gap_retry <= 1'b1;
              state     <= GAP;
            end else begin
              state <= ERROR;
            end
          end else if (cnt <= 32'd1) begin
            state <= ERROR;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        DELAY: begin
          if (cnt <= 32'd1) begin
            cnt       <= GAP_LOAD;
            gap_retry <= 1'b0;
            state     <= GAP;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        GAP: begin
          if (cnt <= 32'd1) begin
            if (gap_retry) begin
              state <= ISSUE;
            end else if (step_idx == 6'd63) begin
              // last slot processed without an end marker: stop, never wrap
              state <= DONE;
            end else begin
              step_idx <= step_idx + 6'd1;
              state    <= FETCH;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        DONE: begin
          init_done <= 1'b1;
          init_busy <= 1'b0;
          state     <= IDLE;
        end

        ERROR: begin
          init_err  <= 1'b1;
          init_busy <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
// tb/tb_sccb_init_seq.sv - directed self-checking bench for sccb_init_seq
//
// Purpose: drives go/reset and models the SCCB master (fixed 5-cycle
// completion latency, optional NACK on one register, optional no-response).
// Ports: none (top-level bench).

module tb_sccb_init_seq;

  localparam int G   = 16;   // GAP_CYCLES
  localparam int PD  = 10;   // POWERUP_UNITS * DELAY_UNIT_CYCLES
  localparam int LAT = 5;    // master start-to-done latency
  localparam int TMO = 50;   // TIMEOUT_CYCLES

  // entries: 12/80, 11/01, delay 3, 3A/04, end
  localparam logic [1023:0] TBL = {{59{16'hFFFF}}, 16'hFFFF, 16'h3A04,
                                   16'hFF03, 16'h1101, 16'h1280};

`ifdef SCCB_INIT_RETRY_EN
  localparam int NACK_STARTS = 4;
`else
  localparam int NACK_STARTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic       sccb_start;
  logic [7:0] sccb_dev_addr;
  logic [7:0] sccb_reg_addr;
  logic [7:0] sccb_wdata;
  logic       busy_in;
  logic       done_in;
  logic       nack_in;
  logic       init_busy;
  logic       init_done;
  logic       init_err;
  logic [5:0] step_idx;

  logic       m_busy;
  logic       force_busy;
  logic       no_resp;
  logic [7:0] nack_reg;
  int         m_pend;
  logic       m_pend_nack;

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  logic [7:0] st_reg[$];
  logic [7:0] st_dat[$];
  int         st_cyc[$];
  int         last_done_cyc;
  int         done_rise;
  int         err_rise;
  logic       prev_done;
  logic       prev_err;
  int         go_cyc;
  int         rel_cyc;
  int         n11;

  assign busy_in = m_busy | force_busy;

  sccb_init_seq #(
    .DEV_ADDR          (8'h42),
    .DELAY_UNIT_CYCLES (10),
    .POWERUP_UNITS     (8'd1),
    .GAP_CYCLES        (G),
    .TIMEOUT_CYCLES    (TMO),
    .MAX_RETRY         (3),
    .TABLE_OVERRIDE    (1'b1),
    .TABLE_IMAGE       (TBL)
  ) dut (
    .sys_clock     (clk),
    .reset         (rst),
    .go            (go),
    .sccb_start    (sccb_start),
    .sccb_dev_addr (sccb_dev_addr),
    .sccb_reg_addr (sccb_reg_addr),
    .sccb_wdata    (sccb_wdata),
    .sccb_busy     (busy_in),
    .sccb_done     (done_in),
    .sccb_nack     (nack_in),
    .init_busy     (init_busy),
    .init_done     (init_done),
    .init_err      (init_err),
    .step_idx      (step_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, then update the master model.
  task automatic step();
    @(posedge clk);
    #1;
    if (init_done && !prev_done) done_rise = cyc;
    if (init_err && !prev_err) err_rise = cyc;
    prev_done = init_done;
    prev_err  = init_err;
    if (done_in) begin
      done_in = 1'b0;
      nack_in = 1'b0;
      m_busy  = 1'b0;
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        done_in       = 1'b1;
        nack_in       = m_pend_nack;
        last_done_cyc = cyc;
      end
    end
    if (sccb_start) begin
      st_reg.push_back(sccb_reg_addr);
      st_dat.push_back(sccb_wdata);
      st_cyc.push_back(cyc);
      m_busy = 1'b1;
      if (!no_resp) begin
        m_pend      = LAT;
        m_pend_nack = (sccb_reg_addr == nack_reg);
      end
    end
  endtask

  task automatic clr();
    st_reg.delete();
    st_dat.delete();
    st_cyc.delete();
    last_done_cyc = -1;
    done_rise     = -1;
    err_rise      = -1;
  endtask

  task automatic master_idle();
    m_busy  = 1'b0;
    m_pend  = 0;
    done_in = 1'b0;
    nack_in = 1'b0;
  endtask

  task automatic start_seq(input string tag);
    clr();
    go     = 1'b1;
    go_cyc = cyc;
    step();
    check({tag, "_busy_after_go"}, init_busy, 1);
    check({tag, "_flags_cleared"}, {init_done, init_err}, 0);
    go = 1'b0;
  endtask

  task automatic run_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while (init_busy && n < maxc) begin
      step();
      n++;
    end
    check({tag, "_finished"}, init_busy, 0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; force_busy = 1'b0; no_resp = 1'b0; nack_reg = 8'h00;
    prev_done = 1'b0; prev_err = 1'b0; m_pend_nack = 1'b0;
    master_idle();
    clr();
    repeat (3) step();

    // reset state
    check("rst_start", sccb_start, 0);
    check("rst_addr_data", {sccb_reg_addr, sccb_wdata}, 0);
    check("rst_flags", {init_busy, init_done, init_err}, 0);
    check("rst_step", step_idx, 0);
    check("dev_addr", sccb_dev_addr, 8'h42);
    rst = 1'b0;
    repeat (2) step();

    // nominal run with an inline 3-unit delay
    start_seq("nom");
    run_idle("nom", 600);
    check("nom_starts", st_cyc.size(), 3);
    check("nom_first_latency", st_cyc[0] - go_cyc, PD + 3);
    check("nom_w0", {st_reg[0], st_dat[0]}, 16'h1280);
    check("nom_w1", {st_reg[1], st_dat[1]}, 16'h1101);
    check("nom_w2", {st_reg[2], st_dat[2]}, 16'h3A04);
    check("nom_done_to_start", st_cyc[1] - (st_cyc[0] + LAT), G + 3);
    check("nom_delay_sep", (st_cyc[2] - st_cyc[1]) >= (30 + G), 1);
    check("nom_end_latency", done_rise - last_done_cyc, G + 3);
    check("nom_flags", {init_done, init_err}, 2'b10);
    check("nom_step", step_idx, 4);

    // NACK on entry 1
    nack_reg = 8'h11;
    start_seq("nack");
    run_idle("nack", 1000);
    n11 = 0;
    foreach (st_reg[i]) if (st_reg[i] == 8'h11) n11++;
    check("nack_entry1_starts", n11, NACK_STARTS);
    check("nack_total_starts", st_cyc.size(), NACK_STARTS + 1);
    check("nack_flags", {init_done, init_err}, 2'b01);
    check("nack_step", step_idx, 1);
    nack_reg = 8'h00;
    master_idle();

    // timeout: master never completes
    no_resp = 1'b1;
    start_seq("tmo");
    run_idle("tmo", 300);
    check("tmo_err_latency", err_rise - st_cyc[0], TMO);
    check("tmo_flags", {init_done, init_err}, 2'b01);
    check("tmo_step", step_idx, 0);
    repeat (30) step();
    check("tmo_no_more_starts", st_cyc.size(), 1);
    no_resp = 1'b0;
    master_idle();

    // busy hold: master busy for 200 cycles once ISSUE is reached
    force_busy = 1'b1;
    start_seq("busy");
    rel_cyc = go_cyc + PD + 3 + 200;
    while (cyc < rel_cyc) step();
    check("busy_withheld", st_cyc.size(), 0);
    force_busy = 1'b0;
    run_idle("busy", 600);
    check("busy_start_after_release", st_cyc[0] - rel_cyc, 1);
    check("busy_flags", {init_done, init_err}, 2'b10);

    // reset in the cycle sccb_start is high, then a clean rerun
    no_resp = 1'b1;
    start_seq("rst");
    begin
      int n;
      n = 0;
      while (!sccb_start && n < 100) begin
        step();
        n++;
      end
    end
    check("rst_seen_start", sccb_start, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_start", sccb_start, 0);
    check("rst_mid_addr_data", {sccb_reg_addr, sccb_wdata}, 0);
    check("rst_mid_flags", {init_busy, init_done, init_err}, 0);
    check("rst_mid_step", step_idx, 0);
    no_resp = 1'b0;
    master_idle();
    repeat (2) step();
    rst = 1'b0;
    step();
    start_seq("rerun");
    begin
      int n;
      n = 0;
      while (st_cyc.size() == 0 && n < 100) begin
        step();
        n++;
      end
    end
    go = 1'b1;                  // should be ignored while busy
    step();
    go = 1'b0;
    run_idle("rerun", 600);
    check("rerun_starts", st_cyc.size(), 3);
    check("rerun_w0", {st_reg[0], st_dat[0]}, 16'h1280);
    check("rerun_flags", {init_done, init_err}, 2'b10);
    check("rerun_step", step_idx, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
